// File: rtl/kara_pkg.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module   : kara_pkg
// Purpose  : Shared definitions for the Karatsuba 128x128 multiplier:
//            default operand width and half width, and the sequencer
//            state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package kara_pkg;

  localparam int KARA_W = 128;        // operand width (must be even)
  localparam int KARA_H = KARA_W / 2; // half width

  // One state per partial product plus the final recombination step.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P0   = 3'd1,
    P2   = 3'd2,
    PM   = 3'd3,
    CMB  = 3'd4
  } kara_state_e;

endpackage : kara_pkg
`default_nettype wire

// File: rtl/kara_mul.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module   : kara_mul
// Purpose  : Combinational unsigned (H+1)x(H+1) multiplier. A single
//            instance is time-shared by the top level for all three
//            Karatsuba partial products; the extra bit covers the carry
//            out of the half-word sums used for the middle product.
// Ports    : a [H:0]     - first operand, unsigned
//            b [H:0]     - second operand, unsigned
//            p [2H+1:0]  - full-width product a*b
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module kara_mul
  import kara_pkg::*;
#(
  parameter int H = KARA_H
) (
  input  logic [H:0]     a,
  input  logic [H:0]     b,
  output logic [2*H+1:0] p
);

  // Zero-extend both operands to the result width so the product is
  // evaluated at full precision with no truncation.
  always_comb begin
    p = {{(H+1){1'b0}}, a} * {{(H+1){1'b0}}, b};
  end

endmodule : kara_mul
`default_nettype wire

// File: rtl/kara_top.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module   : kara_top
// Purpose  : Sequential WxW unsigned multiplier using one level of
//            Karatsuba decomposition. A rising edge on start launches an
//            operation from IDLE; the three half-width partial products are
//            formed on consecutive cycles by one shared multiplier and then
//            recombined into the 2W-bit product held on z.
//            Sequence: IDLE -> P0 -> P2 -> PM -> CMB -> IDLE (5 cycles).
// Ports    : clk    - clock, rising edge
//            rst_n  - asynchronous active-low reset
//            start  - launch request, rising-edge sensitive
//            x, y   - W-bit unsigned operands, sampled only at launch
//            z      - 2W-bit registered product, held between operations
//            done   - (KARA_DONE_EN) one-cycle pulse with each new z
//            busy   - (KARA_DONE_EN) high whenever the sequencer is not IDLE
// Config   : define KARA_DONE_EN to add the done/busy status outputs.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module kara_top
  import kara_pkg::*;
#(
  parameter int W = KARA_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic [2*W-1:0] z
`ifdef KARA_DONE_EN
  ,
  output logic           done,
  output logic           busy
`endif
);

  localparam int H = W / 2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  kara_state_e     state_q, state_d;
  logic            start_dly_q, start_dly_d;
  logic [W-1:0]    xa_q, xa_d;
  logic [W-1:0]    ya_q, ya_d;
  logic [2*H-1:0]  p0_q, p0_d;
  logic [2*H-1:0]  p2_q, p2_d;
  logic [2*H+1:0]  pm_q, pm_d;
  logic [2*W-1:0]  z_q,  z_d;
`ifdef KARA_DONE_EN
  logic            done_q, done_d;
`endif

  // ---------------------------------------------------------------------------
  // Combinational datapath
  // ---------------------------------------------------------------------------
  logic            launch;
  logic [H:0]      mul_a, mul_b;
  logic [2*H+1:0]  mul_p;
  logic [2*H+1:0]  mid;
  logic [2*W-1:0]  cmb_sum;

  assign launch = start & ~start_dly_q;

  // Operand steering for the shared multiplier. Low/high halves are
  // zero-extended; the middle product uses the (H+1)-bit half-word sums.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      P0: begin
        mul_a = {1'b0, xa_q[H-1:0]};
        mul_b = {1'b0, ya_q[H-1:0]};
      end
      P2: begin
        mul_a = {1'b0, xa_q[W-1:H]};
        mul_b = {1'b0, ya_q[W-1:H]};
      end
      PM: begin
        mul_a = {1'b0, xa_q[H-1:0]} + {1'b0, xa_q[W-1:H]};
        mul_b = {1'b0, ya_q[H-1:0]} + {1'b0, ya_q[W-1:H]};
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  kara_mul #(
    .H (H)
  ) u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  // pm >= p0 + p2 always holds, so the middle term never underflows in
  // 2H+2 bits. p2<<W + p0 is a plain concatenation since p0 < 2^W.
  always_comb begin
    mid     = pm_q - {2'b00, p0_q} - {2'b00, p2_q};
    cmb_sum = {p2_q, p0_q} + ({{(2*W-2*H-2){1'b0}}, mid} << H);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    start_dly_d = start;
    xa_d        = xa_q;
    ya_d        = ya_q;
    p0_d        = p0_q;
    p2_d        = p2_q;
    pm_d        = pm_q;
    z_d         = z_q;
`ifdef KARA_DONE_EN
    done_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // Launches in any other state are dropped, not queued.
        if (launch) begin
          xa_d    = x;
          ya_d    = y;
          state_d = P0;
        end
      end
      P0: begin
        p0_d    = mul_p[2*H-1:0];
        state_d = P2;
      end
      P2: begin
        p2_d    = mul_p[2*H-1:0];
        state_d = PM;
      end
      PM: begin
        pm_d    = mul_p;
        state_d = CMB;
      end
      CMB: begin
        z_d     = cmb_sum;
`ifdef KARA_DONE_EN
        done_d  = 1'b1;
`endif
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      start_dly_q <= 1'b0;
      xa_q        <= '0;
      ya_q        <= '0;
      p0_q        <= '0;
      p2_q        <= '0;
      pm_q        <= '0;
      z_q         <= '0;
`ifdef KARA_DONE_EN
      done_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      start_dly_q <= start_dly_d;
      xa_q        <= xa_d;
      ya_q        <= ya_d;
      p0_q        <= p0_d;
      p2_q        <= p2_d;
      pm_q        <= pm_d;
      z_q         <= z_d;
`ifdef KARA_DONE_EN
      done_q      <= done_d;
`endif
    end
  end

  assign z = z_q;
`ifdef KARA_DONE_EN
  assign done = done_q;
  assign busy = (state_q != IDLE);
`endif

endmodule : kara_top
`default_nettype wire

// File: tb/tb_kara_top.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_kara_top
// Purpose  : Self-checking bench for kara_top. Directed operand table,
//            hand-written protocol sequences (held start, start while busy,
//            mid-operation reset) and random operands checked against a
//            plain x*y reference product.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_kara_top;

  localparam int W = 128;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   x;
  logic [W-1:0]   y;
  logic [2*W-1:0] z;
`ifdef KARA_DONE_EN
  logic           done;
  logic           busy;
`endif

  kara_top #(
    .W (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x     (x),
    .y     (y),
    .z     (z)
`ifdef KARA_DONE_EN
    ,
    .done  (done),
    .busy  (busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2*W-1:0] z_exp;   // product the bench expects z to be holding

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
    string          name;
  } vec_t;

  vec_t vecs[7];

  // Reference product straight from arithmetic.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] ea, eb;
    ea = {{W{1'b0}}, a};
    eb = {{W{1'b0}}, b};
    return ea * eb;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] v;
    v = {$urandom, $urandom, $urandom, $urandom};
    case ($urandom_range(0, 7))
      0: v[W-1:W/2] = '1;               // all-ones high half
      1: v[W/2-1:0] = '1;               // all-ones low half
      2: v = '1;
      3: v = v >> $urandom_range(0, W-1);
      default: ;
    endcase
    return v;
  endfunction

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // One operation. Called at a negedge with start low in the previous sampled
  // cycle. The sampling edge is edge 1; the new z must appear on edge 5 and
  // the old value must still be there after edge 4. With disturb set, x/y are
  // scrambled and a start pulse is issued while busy; neither may matter.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input string name,
                        input bit hold_start, input bit disturb);
    x = a; y = b; start = 1'b1;
    @(posedge clk);                                   // edge 1: launch
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    if (disturb) x = rnd_op();
    @(posedge clk);                                   // edge 2
    @(negedge clk);
    if (disturb) begin start = 1'b1; y = rnd_op(); end
    @(posedge clk);                                   // edge 3
    @(negedge clk);
    start = hold_start;
    if (disturb) x = rnd_op();
    @(posedge clk);                                   // edge 4
    @(negedge clk);
    check({name, " held-before"}, z, z_exp);
`ifdef KARA_DONE_EN
    check_bit({name, " done-early"}, done, 1'b0);
`endif
    @(posedge clk);                                   // edge 5: z updates
    @(negedge clk);
    check(name, z, exp);
`ifdef KARA_DONE_EN
    check_bit({name, " done"}, done, 1'b1);
`endif
    z_exp = exp;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]   a, b;
    logic [2*W-1:0] e;

    vecs[0] = '{a: '1, b: '1,
                p: {128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 128'h1},
                name: "all-ones"};
    vecs[1] = '{a: 128'h1 << 64, b: 128'h1 << 64, p: 256'h1 << 128, name: "2^64*2^64"};
    vecs[2] = '{a: 128'hFFFF_FFFF_FFFF_FFFF, b: 128'd3,
                p: 256'h2_FFFF_FFFF_FFFF_FFFD, name: "(2^64-1)*3"};
    vecs[3] = '{a: 128'h0, b: '1, p: 256'h0, name: "zero*ones"};
    vecs[4] = '{a: 128'd1, b: 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE,
                p: 256'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE, name: "one*k"};
    vecs[5] = '{a: '1, b: 128'd2,
                p: 256'h1_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, name: "ones*2"};
    vecs[6] = '{a: 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000,
                b: 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000,
                p: {128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 128'h0},
                name: "hi-ones squared"};

    // Reset
    rst_n = 1'b0; start = 1'b0; x = '0; y = '0;
    z_exp = '0;
    #1000;
    check("reset z", z, 256'h0);
`ifdef KARA_DONE_EN
    check_bit("reset done", done, 1'b0);
    check_bit("reset busy", busy, 1'b0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(6);
    check("idle after reset", z, 256'h0);

    // Held start: exactly one operation despite changing operands.
    run_op(128'h1010 << 32, 128'h1010 << 32, 256'h1020100 << 64, "sparse held", 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      x = rnd_op(); y = rnd_op();
      @(negedge clk);
    end
    check("held start single op", z, z_exp);
    start = 1'b0;
    idle_cycles(2);

    // Directed table
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].name, 1'b0, 1'b0);
    end

    // Start pulse while busy and operand changes mid-flight; nothing queued.
    a = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    b = 128'hFFFF_0000_FFFF_0000_1234_5678_9ABC_DEF0;
    run_op(a, b, ref_mul(a, b), "busy start dropped", 1'b0, 1'b1);
    x = rnd_op(); y = rnd_op();
    idle_cycles(8);
    check("no queued launch", z, z_exp);

    // Random operands, back to back, some with mid-flight disturbance.
    for (int i = 0; i < 1000; i++) begin
      a = rnd_op();
      b = rnd_op();
      e = ref_mul(a, b);
      run_op(a, b, e, $sformatf("random %0d", i), 1'b0, ($urandom_range(0, 3) == 0));
    end

    // Reset while the middle product is being formed.
    idle_cycles(2);
    x = rnd_op(); y = rnd_op(); start = 1'b1;
    @(posedge clk);                 // launch -> P0
    @(negedge clk); start = 1'b0;
    @(posedge clk);                 // -> P2
    @(posedge clk);                 // -> PM
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async reset mid-op", z, 256'h0);
`ifdef KARA_DONE_EN
    check_bit("async reset busy", busy, 1'b0);
`endif
    z_exp = '0;
    idle_cycles(3);
    rst_n = 1'b1;
    idle_cycles(6);
    check("idle after mid-op reset", z, 256'h0);
    a = '1;
    b = 128'h8000_0000_0000_0001_8000_0000_0000_0001;
    run_op(a, b, ref_mul(a, b), "after reset", 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_kara_top
`default_nettype wire
